vd_seq_loader: RTL
==================

Name: vd_seq_loader

Overview:
- Upstream stage of VD_core: assembles one alignment job from a byte stream delivered by the Avalon RS232 polling FSM in VD_Wrapper.
- Unpacks 2-bit base codes into the flat reference and read vectors plus lengths.
- Presents the job to VD_core over a valid/ready handshake and holds it stable until accepted.

Parameters:
- HAP_MAX_LENGTH, 400, max reference bases; sets ref vector width.
- READ_MAX_LENGTH, 150, max read bases; sets read vector width.
- REF_LEN_W, 9, ref length width; must satisfy 2^REF_LEN_W > HAP_MAX_LENGTH.
- READ_LEN_W, 8, read length width; must satisfy 2^READ_LEN_W > READ_MAX_LENGTH.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  reset; synchronous, active-low (asserted when 0).
- i_valid  in  1  byte available on i_data.
- i_data  in  8  stream byte.
- o_ready  out  1  block accepts a byte this cycle.
- o_valid  out  1  job ready for VD_core.
- i_ready  in  1  VD_core accepts the job.
- o_sequence_ref  out  2*HAP_MAX_LENGTH  base i in bits [2i+1:2i].
- o_sequence_read  out  2*READ_MAX_LENGTH  same layout.
- o_seq_ref_length  out  REF_LEN_W  reference length in bases.
- o_seq_read_length  out  READ_LEN_W  read length in bases.
- o_error  out  1  one-cycle pulse on a rejected header.

Behaviour:
- Byte transfer occurs when i_valid && o_ready at a rising clk edge.
- Stream format:
  - byte0 = ref_len[15:8]
  - byte1 = ref_len[7:0]
  - byte2 = read_len
  - then ceil(ref_len/4) ref bytes, then ceil(read_len/4) read bytes.
- Packing is 4 bases per byte; the first base is in bits [7:6]. Codes: A=00, C=01, G=10, T=11.
- Pad bits in the last byte of each payload are ignored.
- FSM states:
  - HDR0, HDR1, HDR2: accept the header bytes.
  - REF, READ: accept payload bytes; a base counter advances by 4 per byte.
  - OUT: job presented to VD_core.
- Transitions:
  - HDR2 -> REF if the header is legal. At that transition both sequence vectors are cleared to 0; unwritten positions read 0.
  - REF -> READ after the last ref byte.
  - READ -> OUT after the last read byte.
  - OUT -> HDR0 when i_ready=1.
- Header legality: 1 <= ref_len <= HAP_MAX_LENGTH and 1 <= read_len <= READ_MAX_LENGTH.
  - Illegal header (including ref_len[15:9] != 0): o_error=1 for exactly the cycle after byte2 is accepted, FSM -> HDR0, no payload is consumed and o_valid is never raised.
- Base writes never index at or beyond the length; the last byte writes only (len mod 4, or 4) bases.
- o_ready: 1 in HDR0/HDR1/HDR2/REF/READ, 0 in OUT.
- o_valid: 1 only in OUT. Output vectors and lengths are registered and stable throughout OUT.
- o_valid && i_ready in the same cycle: handshake completes; o_ready rises the next cycle. No byte is accepted in the handshake cycle.
- Latency: o_valid rises on the cycle after the last read byte is accepted.
- i_valid low mid-payload: FSM waits indefinitely. There is no timeout.
- Reset (rst=0 at a clk edge), from any state including mid-payload or OUT:
  - State -> HDR0.
  - o_valid=0, o_error=0, o_ready=0 during reset and 1 on the first cycle after release.
  - Vectors and lengths = 0; counters = 0.
  - A partially received job is discarded.

Optional Feature:
- Macro: VD_SEQ_LOADER_ASCII_EN.
- Defined: payload is one ASCII base per byte, case-insensitive. 'A'/'a'=00, 'C'/'c'=01, 'G'/'g'=10, 'T'/'t'=11.
  - Payload byte counts equal ref_len and read_len.
  - Any other character stores 00, pulses o_error for one cycle, and loading continues.
  - The header format is unchanged.
- Undefined: packed 2-bit format as above; o_error is driven only by header rejection.

Test Plan:
- Legal packed job: header 0x00,0x05,0x03; ref bytes 0x1B,0x80; read byte 0xE4 -> o_seq_ref_length=5, ref bases 0..4 = 00,01,10,11,10 (A,C,G,T,G); read_length=3, read bases 0..2 = 11,10,01 (T,G,C); all other bits 0; o_valid one cycle after the last byte.
- Backpressure: hold i_ready=0 for 10 cycles in OUT -> o_valid held, outputs stable, o_ready=0, i_valid bytes not consumed; i_ready=1 -> o_valid falls and o_ready=1 the next cycle.
- Illegal header 0x01,0x91,0x0A (ref_len=401) -> o_error pulse one cycle after byte2; next bytes parsed as a new header; a following legal job completes normally.
- Boundary lengths: ref_len=400 (100 bytes of 0xFF), read_len=150 (38 bytes of 0x00) -> all 400 ref bases = 11, read bases all 00, lengths 400/150. Also read_len=0 -> o_error.
- Reset mid-REF after 3 payload bytes (rst=0 for one edge) -> outputs zero and o_valid=0; a full new job afterwards yields correct outputs with no residue from the aborted job.
- With VD_SEQ_LOADER_ASCII_EN: header 0x00,0x03,0x02; payload "AcT","gX" -> ref = 00,01,11; read = 10,00; o_error pulses on 'X'; o_valid=1 afterwards.

Source files
------------

// File: rtl/vd_seq_loader_if.sv
// Byte-stream and job handshake bundle between the RS232 polling FSM, vd_seq_loader and VD_core.
// The slave modport is the loader; the master modport is its environment (stream source plus VD_core).
interface vd_seq_loader_if #(
  parameter int HAP_MAX_LENGTH  = 400,
  parameter int READ_MAX_LENGTH = 150,
  parameter int REF_LEN_W       = 9,
  parameter int READ_LEN_W      = 8
);
  logic                         i_valid;
  logic [7:0]                   i_data;
  logic                         o_ready;
  logic                         o_valid;
  logic                         i_ready;
  logic [2*HAP_MAX_LENGTH-1:0]  o_sequence_ref;
  logic [2*READ_MAX_LENGTH-1:0] o_sequence_read;
  logic [REF_LEN_W-1:0]         o_seq_ref_length;
  logic [READ_LEN_W-1:0]        o_seq_read_length;
  logic                         o_error;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sequence_ref, o_sequence_read,
           o_seq_ref_length, o_seq_read_length, o_error
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sequence_ref, o_sequence_read,
           o_seq_ref_length, o_seq_read_length, o_error
  );
endinterface

// File: rtl/vd_seq_loader.sv
// Assembles one alignment job (header + 2-bit packed payload) and hands it to VD_core over valid/ready.
// Define VD_SEQ_LOADER_ASCII_EN for one case-insensitive ASCII base letter per payload byte instead.
module vd_seq_loader #(
  parameter int HAP_MAX_LENGTH  = 400,
  parameter int READ_MAX_LENGTH = 150,
  parameter int REF_LEN_W       = 9,
  parameter int READ_LEN_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  vd_seq_loader_if.slave bus
);

  localparam int CNT_W = REF_LEN_W + 1;
`ifdef VD_SEQ_LOADER_ASCII_EN
  localparam int BPB = 1;
`else
  localparam int BPB = 4;
`endif
  localparam logic [15:0]      REF_MAX  = 16'(HAP_MAX_LENGTH);
  localparam logic [7:0]       READ_MAX = 8'(READ_MAX_LENGTH);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(BPB);

  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_HDR2, S_REF, S_READ, S_OUT} state_t;

  state_t                       state_q, state_d;
  logic [15:0]                  hdr_q, hdr_d;
  logic [2*HAP_MAX_LENGTH-1:0]  ref_q, ref_d;
  logic [2*READ_MAX_LENGTH-1:0] read_q, read_d;
  logic [REF_LEN_W-1:0]         ref_len_q, ref_len_d;
  logic [READ_LEN_W-1:0]        read_len_q, read_len_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         error_q, error_d;

  logic                         accept;
  logic                         hdr_legal;
  logic                         last_byte;
  logic [CNT_W-1:0]             cur_len;
  logic [CNT_W-1:0]             idx;
  logic [1:0]                   code;

`ifdef VD_SEQ_LOADER_ASCII_EN
  logic [2:0] ascii_dec;

  // Returns {bad, code}; clearing bit 5 folds lower case onto upper case.
  function automatic logic [2:0] ascii_code(input logic [7:0] b);
    unique case (b & 8'hDF)
      8'h41:   return 3'b000;
      8'h43:   return 3'b001;
      8'h47:   return 3'b010;
      8'h54:   return 3'b011;
      default: return 3'b100;
    endcase
  endfunction
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    hdr_d      = hdr_q;
    ref_d      = ref_q;
    read_d     = read_q;
    ref_len_d  = ref_len_q;
    read_len_d = read_len_q;
    cnt_d      = cnt_q;
    error_d    = 1'b0;
    idx        = '0;
    code       = 2'b00;
`ifdef VD_SEQ_LOADER_ASCII_EN
    ascii_dec  = ascii_code(bus.i_data);
`endif

    accept    = bus.i_valid && (state_q != S_OUT);
    hdr_legal = (hdr_q != 16'd0) && (hdr_q <= REF_MAX) &&
                (bus.i_data != 8'd0) && (bus.i_data <= READ_MAX);
    cur_len   = (state_q == S_READ) ? CNT_W'(read_len_q) : CNT_W'(ref_len_q);
    last_byte = (cnt_q + CNT_STEP) >= cur_len;

    unique case (state_q)
      S_HDR0: if (accept) begin
        hdr_d[15:8] = bus.i_data;
        state_d     = S_HDR1;
      end
      S_HDR1: if (accept) begin
        hdr_d[7:0] = bus.i_data;
        state_d    = S_HDR2;
      end
      S_HDR2: if (accept) begin
        if (hdr_legal) begin
          ref_len_d  = hdr_q[REF_LEN_W-1:0];
          read_len_d = READ_LEN_W'(bus.i_data);
          ref_d      = '0;
          read_d     = '0;
          cnt_d      = '0;
          state_d    = S_REF;
        end else begin
          error_d = 1'b1;
          state_d = S_HDR0;
        end
      end
      S_REF, S_READ: if (accept) begin
        // Bases at or past the length are pad and are never written.
        for (int k = 0; k < BPB; k++) begin
          idx = cnt_q + CNT_W'(k);
`ifdef VD_SEQ_LOADER_ASCII_EN
          code = ascii_dec[1:0];
`else
          code = bus.i_data[7-2*k -: 2];
`endif
          if (idx < cur_len) begin
            if (state_q == S_REF) ref_d[2*int'(idx) +: 2] = code;
            else                  read_d[2*int'(idx) +: 2] = code;
          end
        end
`ifdef VD_SEQ_LOADER_ASCII_EN
        error_d = ascii_dec[2];
`endif
        if (last_byte) begin
          cnt_d   = '0;
          state_d = (state_q == S_REF) ? S_READ : S_OUT;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      S_OUT: if (bus.i_ready) state_d = S_HDR0;
      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the job vectors are reset too, so an aborted job can never leak into the outputs.
    if (!rst) begin
      state_q    <= S_HDR0;
      hdr_q      <= '0;
      ref_q      <= '0;
      read_q     <= '0;
      ref_len_q  <= '0;
      read_len_q <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      ref_q      <= ref_d;
      read_q     <= read_d;
      ref_len_q  <= ref_len_d;
      read_len_q <= read_len_d;
      cnt_q      <= cnt_d;
      error_q    <= error_d;
    end
  end

  // o_ready is masked by rst so no byte looks accepted while reset is held.
  assign bus.o_ready           = rst && (state_q != S_OUT);
  assign bus.o_valid           = (state_q == S_OUT);
  assign bus.o_sequence_ref    = ref_q;
  assign bus.o_sequence_read   = read_q;
  assign bus.o_seq_ref_length  = ref_len_q;
  assign bus.o_seq_read_length = read_len_q;
  assign bus.o_error           = error_q;

endmodule
